// File: rtl/scmp_bus_pak.sv
`default_nettype none
// ============================================================================
// Module   : scmp_bus_pak
// Brief    : Shared types and data-bus lane layout for the SC/MP bus controller.
// Revision : 1.0
// ============================================================================
package scmp_bus_pak;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        ADS  = 3'd2,
        RW   = 3'd3,
        DONE = 3'd4
    } BUS_STATE_t;

    typedef struct packed {
        logic h;
        logic d;
        logic i;
        logic r;
    } BUS_FLAGS_t;

    // Flag lanes occupy the upper DB nibble during the address strobe; A15..12 sit below.
    localparam int DB_F_R_BIT = 4;
    localparam int DB_F_I_BIT = 5;
    localparam int DB_F_D_BIT = 6;
    localparam int DB_F_H_BIT = 7;

    function automatic logic [7:0] ads_db_word(input BUS_FLAGS_t f, input logic [3:0] a_hi);
        logic [7:0] w;
        w             = {4'b0000, a_hi};
        w[DB_F_R_BIT] = f.r;
        w[DB_F_I_BIT] = f.i;
        w[DB_F_D_BIT] = f.d;
        w[DB_F_H_BIT] = f.h;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scmp_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : scmp_bus_arb
// Brief    : Daisy-chain bus arbitration: BREQ, grant detection, ENOUT pass-through.
// Revision : 1.0
// ============================================================================
module scmp_bus_arb
    import scmp_bus_pak::*;
(
    input  logic want_i,
    input  logic busy_i,
    input  logic enin_i,
    output logic breq_o,
    output logic enout_o,
    output logic granted_o
);

    assign breq_o    = want_i;
    assign granted_o = want_i & enin_i;
    // The grant only travels down the chain when this block neither holds nor wants the bus.
    assign enout_o   = enin_i & ~want_i & ~busy_i;

endmodule
`default_nettype wire

// File: rtl/scmp_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : scmp_bus_ctl
// Brief    : SC/MP external bus cycle controller; stall is the sequencer clock enable.
//            Optional hold-timeout abort enabled by defining SCMP_BUS_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module scmp_bus_ctl
    import scmp_bus_pak::*;
#(
    parameter int ADS_CYCLES    = 1,
    parameter int RW_MIN_CYCLES = 2,
    parameter int HOLD_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uc_ads_n,
    input  logic        uc_rd_n,
    input  logic        uc_wr_n,
    input  logic [3:0]  uc_flags,
    input  logic [15:0] addr_i,
    input  logic [7:0]  wr_data_i,
    output logic [7:0]  rd_data_o,
    output logic        stall,
    output logic        bus_err,
    output logic        breq_o,
    input  logic        enin_i,
    output logic        enout_o,
    input  logic        hold_i,
    output logic        nads_n,
    output logic        nrds_n,
    output logic        nwds_n,
    output logic [11:0] a_o,
    output logic        a_oe,
    output logic [7:0]  db_o,
    input  logic [7:0]  db_i,
    output logic        db_oe
);

    localparam logic [2:0] c_ADS_LAST = 3'(ADS_CYCLES - 1);
    localparam logic [2:0] c_RW_LAST  = 3'(RW_MIN_CYCLES - 1);

    BUS_STATE_t  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    BUS_FLAGS_t  flags_q, flags_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rd_q, rd_d;
    logic        dir_wr_q, dir_wr_d;

    logic        w_req;
    logic        w_want;
    logic        w_busy;
    logic        w_granted;
    logic        w_abort;
    logic        w_unused_rd;

    assign w_req       = ~uc_ads_n;
    // Direction is decided by uc_wr_n alone, so rd+wr together resolves to a write.
    assign w_unused_rd = uc_rd_n;

    scmp_bus_arb u_arb (
        .want_i    (w_want),
        .busy_i    (w_busy),
        .enin_i    (enin_i),
        .breq_o    (breq_o),
        .enout_o   (enout_o),
        .granted_o (w_granted)
    );

`ifdef SCMP_BUS_TIMEOUT_EN
    localparam int                 c_HTO_W    = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [c_HTO_W-1:0] c_HTO_LAST = c_HTO_W'(HOLD_TIMEOUT - 1);

    logic [c_HTO_W-1:0] hto_q, hto_d;
    logic               err_q;

    assign w_abort = (state_q == RW) && hold_i && (hto_q == c_HTO_LAST);
    assign hto_d   = ((state_q == RW) && hold_i) ? hto_q + c_HTO_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            hto_q <= '0;
            err_q <= 1'b0;
        end else begin
            hto_q <= hto_d;
            err_q <= w_abort;
        end
    end

    assign bus_err = err_q;
`else
    logic w_unused_hold_timeout;
    assign w_unused_hold_timeout = ^HOLD_TIMEOUT;
    assign w_abort               = 1'b0;
    assign bus_err               = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        flags_d  = flags_q;
        wdata_d  = wdata_q;
        dir_wr_d = dir_wr_q;
        rd_d     = rd_q;
        case (state_q)
            IDLE: begin
                if (w_req) begin
                    addr_d   = addr_i;
                    flags_d  = BUS_FLAGS_t'(uc_flags);
                    wdata_d  = wr_data_i;
                    dir_wr_d = ~uc_wr_n;
                    state_d  = w_granted ? ADS : ARB;
                end
            end
            ARB: begin
                if (w_granted) state_d = ADS;
            end
            ADS: begin
                if (cnt_q == c_ADS_LAST) state_d = RW;
            end
            RW: begin
                if (w_abort) begin
                    state_d = DONE;
                    rd_d    = 8'hFF;
                end else if ((cnt_q >= c_RW_LAST) && !hold_i) begin
                    state_d = DONE;
                    if (!dir_wr_q) rd_d = db_i;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Saturate rather than wrap so long hold extensions keep the minimum satisfied.
        if (state_d != state_q)  cnt_d = 3'd0;
        else if (cnt_q == 3'd7)  cnt_d = cnt_q;
        else                     cnt_d = cnt_q + 3'd1;
    end

    always_comb begin
        nads_n = 1'b1;
        nrds_n = 1'b1;
        nwds_n = 1'b1;
        a_oe   = 1'b0;
        db_oe  = 1'b0;
        db_o   = 8'h00;
        stall  = 1'b0;
        w_want = 1'b0;
        w_busy = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                stall  = w_req;
                w_want = w_req;
            end
            ARB: begin
                stall  = 1'b1;
                w_want = 1'b1;
            end
            ADS: begin
                stall  = 1'b1;
                w_want = 1'b1;
                nads_n = 1'b0;
                a_oe   = 1'b1;
                db_oe  = 1'b1;
                db_o   = ads_db_word(flags_q, addr_q[15:12]);
            end
            RW: begin
                stall  = 1'b1;
                w_want = 1'b1;
                a_oe   = 1'b1;
                if (dir_wr_q) begin
                    nwds_n = 1'b0;
                    db_oe  = 1'b1;
                    db_o   = wdata_q;
                end else begin
                    nrds_n = 1'b0;
                end
            end
            DONE: begin
                a_oe = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            addr_q   <= 16'h0000;
            flags_q  <= '0;
            wdata_q  <= 8'h00;
            rd_q     <= 8'h00;
            dir_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            flags_q  <= flags_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            dir_wr_q <= dir_wr_d;
        end
    end

    assign a_o       = addr_q[11:0];
    assign rd_data_o = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_scmp_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scmp_bus_ctl
// Brief    : Directed bench; expected bus phases come from a per-transaction timeline.
// Revision : 1.0
// ============================================================================
module tb_scmp_bus_ctl;

    localparam int ADS_N  = 1;
    localparam int RW_MIN = 2;
    localparam int HTO    = 64;

    typedef enum int {P_IDLE, P_REQ, P_ARB, P_ADS, P_RW, P_DONE} ph_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        uc_ads_n, uc_rd_n, uc_wr_n;
    logic [3:0]  uc_flags;
    logic [15:0] addr_i;
    logic [7:0]  wr_data_i;
    logic [7:0]  rd_data_o;
    logic        stall, bus_err, breq_o, enin_i, enout_o, hold_i;
    logic        nads_n, nrds_n, nwds_n;
    logic [11:0] a_o;
    logic        a_oe;
    logic [7:0]  db_o, db_i;
    logic        db_oe;

    always #5 clk = ~clk;

    scmp_bus_ctl #(
        .ADS_CYCLES    (ADS_N),
        .RW_MIN_CYCLES (RW_MIN),
        .HOLD_TIMEOUT  (HTO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uc_ads_n  (uc_ads_n),
        .uc_rd_n   (uc_rd_n),
        .uc_wr_n   (uc_wr_n),
        .uc_flags  (uc_flags),
        .addr_i    (addr_i),
        .wr_data_i (wr_data_i),
        .rd_data_o (rd_data_o),
        .stall     (stall),
        .bus_err   (bus_err),
        .breq_o    (breq_o),
        .enin_i    (enin_i),
        .enout_o   (enout_o),
        .hold_i    (hold_i),
        .nads_n    (nads_n),
        .nrds_n    (nrds_n),
        .nwds_n    (nwds_n),
        .a_o       (a_o),
        .a_oe      (a_oe),
        .db_o      (db_o),
        .db_i      (db_i),
        .db_oe     (db_oe)
    );

    int          n_pass = 0;
    int          n_tot  = 0;
    bit          chk_en = 1'b0;
    ph_t         ph     = P_IDLE;
    logic [15:0] m_addr  = 16'h0;
    logic [3:0]  m_flags = 4'h0;
    logic [7:0]  m_wdata = 8'h0;
    logic [7:0]  m_rd    = 8'h0;
    bit          m_wr    = 1'b0;
    bit          m_abort = 1'b0;
    int          stall_cnt, nwds_cnt, err_cnt;
    logic [11:0] cap_ads_a;
    logic [7:0]  cap_ads_db, cap_rw_db;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Expected outputs follow directly from the current bus phase and the captured request.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("nads_n", nads_n, ph != P_ADS);
            chk("nrds_n", nrds_n, !(ph == P_RW && !m_wr));
            chk("nwds_n", nwds_n, !(ph == P_RW && m_wr));
            chk("breq_o", breq_o, ph inside {P_REQ, P_ARB, P_ADS, P_RW});
            chk("stall", stall, ph inside {P_REQ, P_ARB, P_ADS, P_RW});
            chk("a_oe", a_oe, ph inside {P_ADS, P_RW, P_DONE});
            chk("db_oe", db_oe, (ph == P_ADS) || (ph == P_RW && m_wr));
            chk("enout_o", enout_o, (ph == P_IDLE) && enin_i);
            chk("rd_data_o", rd_data_o, m_rd);
            chk("bus_err", bus_err, (ph == P_DONE) && m_abort);
            if (ph inside {P_ADS, P_RW, P_DONE}) chk("a_o", a_o, m_addr[11:0]);
            if (ph == P_ADS) chk("db_o_ads", db_o, {m_flags, m_addr[15:12]});
            if (ph == P_RW && m_wr) chk("db_o_wr", db_o, m_wdata);
            if (ph == P_ADS) begin
                cap_ads_a  = a_o;
                cap_ads_db = db_o;
            end
            if (ph == P_RW && m_wr) cap_rw_db = db_o;
            stall_cnt += int'(stall === 1'b1);
            nwds_cnt  += int'(nwds_n === 1'b0);
            err_cnt   += int'(bus_err === 1'b1);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            nxt();
            uc_ads_n = 1'b1;
            uc_rd_n  = 1'b1;
            uc_wr_n  = 1'b1;
            enin_i   = 1'b1;
            hold_i   = 1'b0;
            ph       = P_IDLE;
        end
    endtask

    // One bus transaction: request, wait_n ARB cycles, ADS, RW stretched by hold_n, DONE.
    task automatic run_txn(input logic [15:0] addr, input logic [3:0] fl, input logic [7:0] wd,
                           input bit wr, input bit both, input int wait_n, input int hold_n,
                           input logic [7:0] dbi, input bit drop_en, input int rst_at);
        int nh, rw_len;
        bit abort;
        nh        = RW_MIN - 1 + hold_n;
        rw_len    = RW_MIN + hold_n;
        abort     = 1'b0;
`ifdef SCMP_BUS_TIMEOUT_EN
        if (nh >= HTO) begin
            rw_len = HTO;
            abort  = 1'b1;
        end
`endif
        nxt();
        stall_cnt = 0;
        nwds_cnt  = 0;
        m_addr    = addr;
        m_flags   = fl;
        m_wdata   = wd;
        m_wr      = wr;
        uc_ads_n  = 1'b0;
        uc_wr_n   = !wr;
        uc_rd_n   = wr ? !both : 1'b0;
        uc_flags  = fl;
        addr_i    = addr;
        wr_data_i = wd;
        enin_i    = (wait_n == 0);
        hold_i    = 1'b0;
        ph        = P_REQ;
        for (int i = 1; i <= wait_n; i++) begin
            nxt();
            addr_i = ~addr; uc_flags = ~fl; wr_data_i = ~wd;
            enin_i = (i == wait_n);
            ph     = P_ARB;
        end
        for (int i = 0; i < ADS_N; i++) begin
            nxt();
            addr_i = ~addr; uc_flags = ~fl; wr_data_i = ~wd;
            if (drop_en) enin_i = 1'b0;
            ph = P_ADS;
        end
        for (int i = 0; i < rw_len; i++) begin
            nxt();
            hold_i = (i < nh);
            db_i   = (i == rw_len - 1) ? dbi : ~dbi;
            ph     = P_RW;
            if (i == rst_at) begin
                rst = 1'b1;
                nxt();
                rst      = 1'b0;
                uc_ads_n = 1'b1;
                uc_rd_n  = 1'b1;
                uc_wr_n  = 1'b1;
                hold_i   = 1'b0;
                enin_i   = 1'b1;
                m_rd     = 8'h00;
                ph       = P_IDLE;
                chk("rst_mid_a_o", a_o, 12'h000);
                chk("rst_mid_db_o", db_o, 8'h00);
                return;
            end
        end
        nxt();
        hold_i  = 1'b0;
        enin_i  = 1'b1;
        m_abort = abort;
        if (abort)   m_rd = 8'hFF;
        else if (!wr) m_rd = dbi;
        ph = P_DONE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; uc_ads_n = 1'b1; uc_rd_n = 1'b1; uc_wr_n = 1'b1;
        uc_flags = 4'h0; addr_i = 16'h0; wr_data_i = 8'h0;
        enin_i = 1'b1; hold_i = 1'b0; db_i = 8'h00;
        nxt();
        chk_en = 1'b1;
        chk("rst_a_o", a_o, 12'h000);
        chk("rst_db_o", db_o, 8'h00);
        chk("rst_rd_data", rd_data_o, 8'h00);
        nxt();
        rst = 1'b0;
        idle(2);

        run_txn(16'hA123, 4'b0001, 8'h00, 1'b0, 1'b0, 0, 0, 8'h5A, 1'b0, -1);
        idle(2);
        chk("rd_stall_cycles", stall_cnt, 4);
        chk("rd_ads_a_o", cap_ads_a, 12'h123);
        chk("rd_ads_db_o", cap_ads_db, 8'h1A);
        chk("rd_data_5a", rd_data_o, 8'h5A);
        chk("idle_enout", enout_o, 1'b1);
        chk("idle_breq", breq_o, 1'b0);

        run_txn(16'h0FFF, 4'b1010, 8'hC3, 1'b1, 1'b0, 0, 3, 8'h00, 1'b0, -1);
        idle(1);
        chk("wr_nwds_cycles", nwds_cnt, 5);
        chk("wr_stall_cycles", stall_cnt, 7);
        chk("wr_db_o", cap_rw_db, 8'hC3);

        run_txn(16'h5555, 4'b0110, 8'h00, 1'b0, 1'b0, 5, 0, 8'h3C, 1'b1, -1);
        chk("arb_stall_cycles", stall_cnt, 9);
        run_txn(16'h8001, 4'b0100, 8'h81, 1'b1, 1'b1, 0, 1, 8'h00, 1'b0, -1);
        idle(1);
        chk("b2b_rd_data", rd_data_o, 8'h3C);
        chk("both_low_is_write", nwds_cnt, 3);

        run_txn(16'h1234, 4'b0011, 8'h77, 1'b1, 1'b0, 0, 4, 8'h00, 1'b0, 2);
        idle(2);
        chk("rst_mid_rd_data", rd_data_o, 8'h00);

        run_txn(16'hFFFF, 4'b1111, 8'h00, 1'b0, 1'b0, 0, 2, 8'hA5, 1'b0, -1);
        idle(1);
        chk("flags_ads_db_o", cap_ads_db, 8'hFF);
        chk("hold_rd_data", rd_data_o, 8'hA5);

`ifdef SCMP_BUS_TIMEOUT_EN
        err_cnt = 0;
        run_txn(16'h0042, 4'b0000, 8'h00, 1'b0, 1'b0, 0, 100, 8'h11, 1'b0, -1);
        idle(2);
        chk("timeout_rd_data", rd_data_o, 8'hFF);
        chk("timeout_err_pulses", err_cnt, 1);
        chk("timeout_stall_cycles", stall_cnt, 1 + ADS_N + HTO);
`endif

        idle(2);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scmp_bus_ctl.md
Name: scmp_bus_ctl

Overview:
- External SC/MP bus cycle controller, directly downstream of the microcode sequencer.
- Consumes the sequencer's per-microinstruction bus request strobes (bus_ADS_n, bus_RD_n, bus_WR_n) and the flag bits bus_F_R, bus_F_I, bus_F_D, bus_F_H.
- Arbitrates for the bus (BREQ/ENIN/ENOUT), produces timed NADS/NRDS/NWDS with HOLD wait-state extension, and latches read data.
- Its stall output is the sequencer's clock-enable: mc_pc holds while stall=1.

Parameters:
- ADS_CYCLES, 1, cycles NADS is held low (1..7).
- RW_MIN_CYCLES, 2, minimum cycles NRDS/NWDS is held low before hold_i is sampled (1..7).
- HOLD_TIMEOUT, 64, cycles of continuous hold_i before abort. Only used with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- uc_ads_n  in  1  microcode address-strobe request, active low; low = start a bus cycle
- uc_rd_n  in  1  microcode read request, active low
- uc_wr_n  in  1  microcode write request, active low
- uc_flags  in  4  {F_H,F_D,F_I,F_R} from the sequencer
- addr_i  in  16  address from the address mux
- wr_data_i  in  8  write data from the AC/ALU path
- rd_data_o  out  8  latched read data
- stall  out  1  sequencer hold
- bus_err  out  1  timeout abort pulse (optional feature only)
- breq_o  out  1  bus request
- enin_i  in  1  bus enable in (grant)
- enout_o  out  1  bus enable out to the next device in the chain
- hold_i  in  1  active-high wait-state request
- nads_n  out  1  external address strobe
- nrds_n  out  1  external read strobe
- nwds_n  out  1  external write strobe
- a_o  out  12  address A11..0
- a_oe  out  1  address drive enable
- db_o  out  8  data bus out
- db_i  in  8  data bus in
- db_oe  out  1  data bus drive enable

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk.
- Reset values: nads_n=nrds_n=nwds_n=1, breq_o=0, a_oe=db_oe=0, a_o=0, db_o=0, rd_data_o=0, bus_err=0, state=IDLE, all counters 0.
- Reset mid-cycle: strobes are released and drivers disabled at the reset edge; no partial-cycle completion.
- Request: req = ~uc_ads_n. Sampled only in IDLE.
  - At capture: latch addr_i, uc_flags, wr_data_i, and dir = write if ~uc_wr_n, else read.
  - uc_rd_n and uc_wr_n both low is treated as a write.
- stall = (state==IDLE & req) | (state ∉ {IDLE, DONE}). stall is combinational, so the requesting microinstruction is held from its first cycle.
- States:
  - IDLE: on req, go to ADS if enin_i=1, else ARB.
  - ARB: breq_o=1. Wait for enin_i=1, then go to ADS.
  - ADS: breq_o=1, a_oe=1, db_oe=1, nads_n=0.
    - a_o = addr[11:0]; db_o = {F_H,F_D,F_I,F_R,addr[15:12]}.
    - Stay ADS_CYCLES cycles, then go to RW.
  - RW: nads_n=1; nrds_n=0 for a read, or nwds_n=0 for a write.
    - For a write, db_o = latched write data and db_oe=1. For a read, db_oe=0.
    - Stay at least RW_MIN_CYCLES cycles, then continue while hold_i=1.
    - On the exit cycle, a read captures db_i into rd_data_o. Then go to DONE.
  - DONE: one cycle. All strobes high, db_oe=0, a_oe=1 (address hold), breq_o=0, stall=0, so the sequencer advances. Then go to IDLE.
- enout_o = enin_i & (state==IDLE) & ~req. The grant passes down the chain only when this block is neither using nor wanting the bus.
- enin_i dropping during ADS or RW: ignored; the cycle completes.
- Minimum cycle with enin_i high: 1 (IDLE) + ADS_CYCLES + RW_MIN_CYCLES + 1 (DONE). With defaults, stall is high for 4 cycles.
- Back-to-back requests: the next request is seen in IDLE on the cycle after DONE. No overlap.
- Counters are 3 bits, cleared on every state entry; no wrap is possible within the legal parameter range.

Optional Feature:
- Macro: SCMP_BUS_TIMEOUT_EN.
- With the macro defined: a counter runs while in RW with hold_i=1. When it reaches HOLD_TIMEOUT, the cycle is forced to DONE, rd_data_o is loaded with 8'hFF, and bus_err pulses for 1 cycle (coincident with DONE).
- Without the macro: hold_i extends RW indefinitely, bus_err is tied to 0, and no counter is instantiated.

Decomposition:
- Package scmp_bus_pak holds:
  - BUS_STATE_t enum {IDLE, ARB, ADS, RW, DONE};
  - BUS_FLAGS_t packed struct {h,d,i,r};
  - the DB flag-lane position constants.
- Sub-module scmp_bus_arb holds the breq_o/enin_i/enout_o logic. It takes a want input and a busy input and produces a granted output.

Test Plan:
- Read 16'hA123 with enin_i=1, hold_i=0, db_i=8'h5A, flags 4'b0001 → ADS: a_o=12'h123, db_o=8'h1A; stall high for 4 cycles; rd_data_o=8'h5A at DONE.
- Write 8'hC3 to 16'h0FFF with hold_i high for 3 extra RW cycles → nwds_n low for 5 cycles, db_o=8'hC3 for all of them, stall high for 7 cycles.
- enin_i=0 for 5 cycles then 1 → breq_o high from the request cycle, NADS starts the cycle after the grant, enout_o=0 throughout.
- Idle with enin_i=1, no request → enout_o=1, breq_o=0, all strobes high.
- rst asserted mid-RW → next cycle all strobes high, db_oe=0, stall=0, state=IDLE.
- With SCMP_BUS_TIMEOUT_EN and hold_i stuck at 1 → abort after 64 hold cycles, bus_err 1-cycle pulse, rd_data_o=8'hFF.
